// File: rtl/cp0_if.sv
// Bundles the M-stage CP0 access signals between the pipeline and cp0.
interface cp0_if;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic [4:0]  ExcCode;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] DOut;

   modport master (
      output A1, A2, DIn, WE, PC, ExcCode, HWInt, EXLClr,
      input  IntReq, EPC, DOut
   );

   modport slave (
      input  A1, A2, DIn, WE, PC, ExcCode, HWInt, EXLClr,
      output IntReq, EPC, DOut
   );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: exception/interrupt decision plus SR, Cause, EPC and PrID.
module cp0 #(
   parameter logic [31:0] PRID = 32'h0000_4D4D
) (
   input logic   clk,
   input logic   reset,
   cp0_if.slave  bus
);
   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] SR_NUM    = REG_W'(12);
   localparam logic [REG_W-1:0] CAUSE_NUM = REG_W'(13);
   localparam logic [REG_W-1:0] EPC_NUM   = REG_W'(14);
   localparam logic [REG_W-1:0] PRID_NUM  = REG_W'(15);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic hw;
   logic exc;
   logic int_req;
   logic unused_pc_low;

   assign unused_pc_low = ^bus.PC[1:0];

   // Take decision; forced low in reset so no flush leaks out during reset.
   always_comb begin
      hw      = (|(bus.HWInt & im)) & ie & ~exl;
      exc     = (bus.ExcCode != 5'd0) & ~exl;
      int_req = ~reset & (hw | exc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
      end else begin
         ip <= bus.HWInt;
         if (int_req) begin
            exl      <= 1'b1;
            epc      <= {bus.PC[31:2], 2'b00};
            exc_code <= hw ? 5'd0 : bus.ExcCode;
         end else begin
            if (bus.WE) begin
               if (bus.A2 == SR_NUM) begin
                  im  <= bus.DIn[15:10];
                  exl <= bus.DIn[1];
                  ie  <= bus.DIn[0];
               end else if (bus.A2 == EPC_NUM) begin
                  epc <= {bus.DIn[31:2], 2'b00};
               end
            end
            // eret after the write so a simultaneous SR write still leaves EXL clear
            if (bus.EXLClr) exl <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.DOut = 32'd0;
      case (bus.A1)
         SR_NUM:    bus.DOut = {16'd0, im, 8'd0, exl, ie};
         CAUSE_NUM: bus.DOut = {16'd0, ip, 3'd0, exc_code, 2'b00};
         EPC_NUM:   bus.DOut = epc;
         PRID_NUM:  bus.DOut = PRID;
         default:   bus.DOut = 32'd0;
      endcase
   end

   assign bus.IntReq = int_req;
   assign bus.EPC    = epc;
endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   cp0_if bus ();

   cp0 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
      bus.A1 = a;
      #1;
      check(tag, bus.DOut, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset       = 1'b1;
      bus.A1      = 5'd12;
      bus.A2      = 5'd0;
      bus.DIn     = 32'd0;
      bus.WE      = 1'b0;
      bus.PC      = 32'd0;
      bus.ExcCode = 5'd4;
      bus.HWInt   = 6'd0;
      bus.EXLClr  = 1'b0;
      step();
      step();
      check("intreq_in_reset", 32'(bus.IntReq), 32'd0);
      bus.ExcCode = 5'd0;
      reset = 1'b0;
      step();
      rd(5'd12, 32'd0, "rst_sr");
      rd(5'd13, 32'd0, "rst_cause");
      rd(5'd14, 32'd0, "rst_epc_rd");
      rd(5'd15, 32'h0000_4D4D, "rst_prid");
      rd(5'd3, 32'd0, "rst_other");
      check("rst_epc_out", bus.EPC, 32'd0);

      // synchronous exception
      bus.PC = 32'h0000_3008;
      bus.ExcCode = 5'd10;
      #1;
      check("exc_intreq", 32'(bus.IntReq), 32'd1);
      step();
      check("exc_intreq_exl", 32'(bus.IntReq), 32'd0);
      check("exc_epc", bus.EPC, 32'h0000_3008);
      rd(5'd13, 32'h0000_0028, "exc_cause");
      rd(5'd12, 32'h0000_0002, "exc_sr");
      bus.ExcCode = 5'd0;
      bus.EXLClr = 1'b1;
      step();
      bus.EXLClr = 1'b0;
      rd(5'd12, 32'd0, "eret_sr");

      // enable IM0 and interrupt
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
      step();
      bus.WE = 1'b0;
      rd(5'd12, 32'h0000_0401, "mtc0_sr");
      bus.PC = 32'h0000_4010;
      bus.HWInt = 6'b000001;
      #1;
      check("hw_intreq", 32'(bus.IntReq), 32'd1);
      step();
      rd(5'd13, 32'h0000_0400, "hw_cause");
      check("hw_epc", bus.EPC, 32'h0000_4010);
      rd(5'd12, 32'h0000_0403, "hw_sr");
      check("hw_held_exl", 32'(bus.IntReq), 32'd0);

      // eret with interrupt still pending re-triggers next cycle
      bus.EXLClr = 1'b1;
      step();
      bus.EXLClr = 1'b0;
      bus.PC = 32'h0000_4020;
      #1;
      check("eret_retrigger", 32'(bus.IntReq), 32'd1);
      step();
      check("eret_epc", bus.EPC, 32'h0000_4020);

      // masked interrupt: IM selects line 1 while line 0 is high
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0801;
      step();
      bus.WE = 1'b0;
      check("masked_intreq", 32'(bus.IntReq), 32'd0);
      rd(5'd13, 32'h0000_0400, "masked_ip");

      // interrupt and exception together: interrupt wins
      bus.HWInt = 6'd0;
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
      step();
      bus.WE = 1'b0;
      bus.HWInt = 6'b000001;
      bus.ExcCode = 5'd12;
      bus.PC = 32'h0000_5000;
      #1;
      check("prio_intreq", 32'(bus.IntReq), 32'd1);
      step();
      check("prio_single", 32'(bus.IntReq), 32'd0);
      rd(5'd13, 32'h0000_0400, "prio_cause");
      check("prio_epc", bus.EPC, 32'h0000_5000);

      // SR write and eret in the same cycle: EXL ends cleared
      bus.HWInt = 6'd0;
      bus.ExcCode = 5'd0;
      bus.EXLClr = 1'b1;
      bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
      step();
      bus.EXLClr = 1'b0;
      rd(5'd12, 32'h0000_0401, "we_eret_sr");

      // EPC write aligns; Cause write ignored
      bus.A2 = 5'd14; bus.DIn = 32'h0000_3007;
      step();
      check("mtc0_epc", bus.EPC, 32'h0000_3004);
      bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
      step();
      bus.WE = 1'b0;
      rd(5'd13, 32'd0, "mtc0_cause_ignored");
      rd(5'd14, 32'h0000_3004, "mtc0_epc_rd");

      // write dropped when IntReq fires the same cycle
      bus.ExcCode = 5'd8;
      bus.PC = 32'h0000_6003;
      bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h7777_0000;
      #1;
      check("drop_intreq", 32'(bus.IntReq), 32'd1);
      step();
      bus.WE = 1'b0;
      check("drop_epc", bus.EPC, 32'h0000_6000);
      rd(5'd13, 32'h0000_0020, "drop_cause");

      // reset in the handler clears EXL and EPC
      reset = 1'b1;
      #1;
      check("midrst_intreq", 32'(bus.IntReq), 32'd0);
      step();
      check("midrst_intreq2", 32'(bus.IntReq), 32'd0);
      check("midrst_epc", bus.EPC, 32'd0);
      rd(5'd12, 32'd0, "midrst_sr");
      reset = 1'b0;
      #1;
      check("post_rst_exc", 32'(bus.IntReq), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception and interrupt controller for the pipelined MIPS CPU. It consumes the exception code that travels down the pipeline alongside each instruction (originating in IF), together with the victim PC, at the memory stage. It decides whether to take an exception or hardware interrupt and holds the architectural SR, Cause, EPC and PrID registers. Its `IntReq` output is the `int_clr` flush source for every pipeline register and the redirect request for the PC unit; `EPC` feeds the `eret` target.

## Interface
Parameters:
- `PRID`, 32'h0000_4D4D: value returned by PrID (reg 15); read-only.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high; clears all state on the next posedge.
- `A1`  in  5: CP0 read register number (`mfc0` rd).
- `A2`  in  5: CP0 write register number (`mtc0` rd).
- `DIn`  in  32: `mtc0` write data.
- `WE`  in  1: `mtc0` write enable (M stage).
- `PC`  in  32: PC of the instruction currently in M stage.
- `ExcCode`  in  5: exception code of that instruction; 0 means none.
- `HWInt`  in  6: hardware interrupt lines, level-sensitive.
- `EXLClr`  in  1: `eret` in M stage.
- `IntReq`  out  1: take exception/interrupt this cycle; flushes pipeline and redirects PC.
- `EPC`  out  32: current EPC register.
- `DOut`  out  32: read data for `A1`.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): full 32 bits.
  - PrID (15): constant `PRID`.
- `IntReq` is combinational and forced 0 while `reset`=1. Otherwise, with:
  - `hw = |(HWInt & IM) & IE & ~EXL`
  - `exc = (ExcCode != 0) & ~EXL`
  - `IntReq = hw | exc`
- Per-posedge update priority: reset > IntReq > EXLClr > mtc0 write.
  - **reset**: SR=0, Cause=0, EPC=0.
  - **IntReq**: EXL<=1; EPC<={PC[31:2],2'b00}; Cause.ExcCode<= hw ? 0 : ExcCode (interrupt wins over a simultaneous exception).
  - **EXLClr** (no IntReq): EXL<=0.
  - **WE** (no IntReq): A2=12 writes IM, EXL and IE from DIn; A2=14 writes EPC with DIn[31:2],2'b00. Writes to 13, 15 or any other number are ignored. WE and EXLClr in the same cycle: both apply; EXL ends at 0.
- Cause.IP <= HWInt every cycle, unconditionally except during reset.
- `DOut` is a combinational read of A1 against current register state. A1 outside {12,13,14,15} returns 0. A write made this cycle is visible in DOut from the next cycle; there is no internal bypass.
- `EPC` output is the current register value, not the value being written.
- While EXL=1, both exceptions and interrupts are ignored; a nonzero ExcCode then has no effect.

## Timing
- Reset values: IntReq=0; EPC=0; DOut=0 for A1=12/13/14; DOut=PRID for A1=15.
- IntReq response is zero-latency: same cycle as the qualifying inputs. State changes land at the following posedge.
- EXL=1 from the cycle after IntReq, so IntReq lasts one cycle per event unless EXL is cleared.
- An `eret` taking effect at posedge N re-enables IntReq in cycle N+1. A still-pending HWInt therefore re-triggers one cycle after return.
- Reset asserted mid-handler clears EXL and EPC at that posedge; IntReq stays low throughout reset.

## Test plan
- Reset, then read A1=12..15 and A1=3:
  - -> 0, 0, 0, 32'h0000_4D4D, 0.
  - IntReq=0 even with ExcCode=5'd4 held during reset.
- Exception, PC=32'h0000_3008, ExcCode=5'd10, SR=0:
  - -> IntReq=1 that cycle.
  - Next cycle: EPC=32'h0000_3008, Cause[6:2]=10, SR[1]=1, IntReq=0 despite ExcCode still 10.
- mtc0 SR=32'h0000_0401, then HWInt=6'b000001:
  - -> IntReq=1; Cause.ExcCode=0; EPC=PC; Cause[15:10]=6'b000001.
  - With IM masked (SR=32'h0000_0801): IntReq=0 and IP still sets.
- HWInt enabled plus ExcCode=5'd12 in the same cycle:
  - -> single IntReq; Cause.ExcCode=0 (interrupt priority).
- eret with HWInt held high:
  - -> EXL=0 after the posedge, IntReq=1 the following cycle, EPC updated again.
- mtc0 to A2=14 with DIn=32'h0000_3007, and to A2=13 with any data:
  - -> EPC=32'h0000_3004; Cause unchanged.
  - Write with IntReq=1 in the same cycle -> write dropped.
